cordic_cos_seq: RTL and testbench

Iterative, multi-cycle CORDIC rotation engine with a valid/ready handshake on both sides. It replaces the fully unrolled combinational cos datapath where area matters. A control FSM drives one shared shift-add stage for NUM_ITER cycles per request. The block returns cos and sin of a fixed-point angle in radians and sits between an angle producer and any downstream consumer that can apply backpressure.

---
 rtl/cordic_cos_seq.sv | 143 ++++++++++++++
 tb/tb_cordic_cos_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_cos_seq.sv
// rtl/cordic_cos_seq.sv - iterative CORDIC cos/sin engine with one shared shift-add stage
// Optional macro CORDIC_QUADRANT_FOLD_EN folds angles beyond +-pi/2 by pi and negates the result.
module cordic_cos_seq #(
  parameter int FRAC_BITS = 30,
  parameter int NUM_ITER  = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [FRAC_BITS+1:0] theta_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [FRAC_BITS+1:0] cos_out,
  output logic signed [FRAC_BITS+1:0] sin_out,
  output logic                     busy
);

  localparam int W  = FRAC_BITS + 2;
  localparam int IW = $clog2(FRAC_BITS + 2);

  // Real-valued constant to Q2.FRAC_BITS at W+1 bits, truncated (all callers pass positive values).
  function automatic logic signed [W:0] to_fix(input real r);
    longint v;
    v = longint'($floor(r * (2.0 ** FRAC_BITS)));
    return v[W:0];
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [W:0] v);
    if (v[W] != v[W-1])
      return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return v[W-1:0];
  endfunction

  localparam logic signed [W:0] K_FIX = to_fix(0.6072529350088813);

  logic signed [W-1:0] atan_tab [NUM_ITER];
  for (genvar g = 0; g < NUM_ITER; g++) begin : g_atan
    localparam logic signed [W:0] A_FIX = to_fix($atan(1.0 / (2.0 ** g)));
    assign atan_tab[g] = A_FIX[W-1:0];
  end

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  state_t state, state_nx;

  logic signed [W:0]   x, y, x_sh, y_sh, x_nx, y_nx, res_x, res_y;
  logic signed [W-1:0] z, z_nx, z_load;
  logic [IW-1:0]       i;
  logic                last_iter, z_neg;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign last_iter = (i == IW'(NUM_ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = ROTATE;
      ROTATE:  if (last_iter) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One micro-rotation; direction follows the sign of the residual angle.
  assign z_neg = z[W-1];
  assign x_sh  = x >>> i;
  assign y_sh  = y >>> i;
  assign x_nx  = z_neg ? x + y_sh : x - y_sh;
  assign y_nx  = z_neg ? y - x_sh : y + x_sh;
  assign z_nx  = z_neg ? z + atan_tab[i] : z - atan_tab[i];

`ifdef CORDIC_QUADRANT_FOLD_EN
  localparam logic signed [W:0]   PI_FIX   = to_fix(3.141592653589793);
  localparam logic signed [W:0]   HPI_FIX  = to_fix(1.5707963267948966);
  localparam logic signed [W-1:0] PI_LO    = PI_FIX[W-1:0];
  localparam logic signed [W-1:0] HPI_LO   = HPI_FIX[W-1:0];
  logic fold, fold_load;

  // Only the low W bits of the W+1-bit difference survive, so W-bit arithmetic is equivalent.
  always_comb begin
    z_load    = theta_in;
    fold_load = 1'b0;
    if (theta_in > HPI_LO) begin
      z_load    = theta_in - PI_LO;
      fold_load = 1'b1;
    end else if (theta_in < -HPI_LO) begin
      z_load    = theta_in + PI_LO;
      fold_load = 1'b1;
    end
  end

  assign res_x = fold ? -x_nx : x_nx;
  assign res_y = fold ? -y_nx : y_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                fold <= 1'b0;
    else if (state == IDLE && in_valid)     fold <= fold_load;
  end
`else
  assign z_load = theta_in;
  assign res_x  = x_nx;
  assign res_y  = y_nx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      z       <= '0;
      i       <= '0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x <= K_FIX;
          y <= '0;
          z <= z_load;
          i <= '0;
        end
        ROTATE: begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
          i <= i + 1'b1;
          if (last_iter) begin
            cos_out <= sat(res_x);
            sin_out <= sat(res_y);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cos_seq.sv
// tb/tb_cordic_cos_seq.sv - directed self-checking bench for cordic_cos_seq
module tb_cordic_cos_seq;
  localparam int FB  = 30;
  localparam int NI  = 30;
  localparam int W   = FB + 2;
  localparam int TOL = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [W-1:0] theta_in = '0;
  logic in_ready, out_valid, busy;
  logic signed [W-1:0] cos_out, sin_out;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_cos_seq #(.FRAC_BITS(FB), .NUM_ITER(NI)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .theta_in(theta_in),
    .out_valid(out_valid), .out_ready(out_ready), .cos_out(cos_out), .sin_out(sin_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_cos(input int th);
    real r;
    r = real'(th) / (2.0 ** FB);
    return $rtoi($cos(r) * (2.0 ** FB));
  endfunction

  function automatic int ref_sin(input int th);
    real r;
    r = real'(th) / (2.0 ** FB);
    return $rtoi($sin(r) * (2.0 ** FB));
  endfunction

  // Issue one request from idle; returns negedges until out_valid and how often in_ready was seen high.
  task automatic do_txn(input int th, output int lat, output int c, output int s, output int ir_hi);
    @(negedge clk);
    theta_in = th;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    ir_hi = in_ready ? 1 : 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (in_ready) ir_hi++;
    end
    c = cos_out;
    s = sin_out;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", {in_ready, out_valid, busy});
    end
    n_cmp++;
    if (cos_out !== '0 || sin_out !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got cos=%0d sin=%0d want 0 0", cos_out, sin_out);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_zero();
    int lat, c, s, ir;
    out_ready = 1'b1;
    do_txn(0, lat, c, s, ir);
    n_cmp++;
    if (lat !== NI) begin
      n_bad++;
      $display("FAIL zero_latency: got %0d want %0d", lat, NI);
    end
    n_cmp++;
    if (c - (1 << FB) > TOL || (1 << FB) - c > TOL || s > TOL || -s > TOL) begin
      n_bad++;
      $display("FAIL zero_value: got cos=%0d sin=%0d want %0d 0", c, s, 1 << FB);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL zero_one_cycle: got valid/ready/busy=%b want 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_angles();
    int thetas [4] = '{842887823, -536870912, 1686629713, -1686629713};
    int lat, c, s, ir, ec, es;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_txn(thetas[k], lat, c, s, ir);
      ec = ref_cos(thetas[k]);
      es = ref_sin(thetas[k]);
      n_cmp++;
      if (c - ec > TOL || ec - c > TOL) begin
        n_bad++;
        $display("FAIL angle_cos[%0d]: got %0d want %0d", k, c, ec);
      end
      n_cmp++;
      if (s - es > TOL || es - s > TOL) begin
        n_bad++;
        $display("FAIL angle_sin[%0d]: got %0d want %0d", k, s, es);
      end
      n_cmp++;
      if (ir !== 0 || lat !== NI) begin
        n_bad++;
        $display("FAIL angle_handshake[%0d]: got in_ready_hi=%0d lat=%0d want 0 %0d", k, ir, lat, NI);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat, c, s, ir, bad;
    out_ready = 1'b0;
    do_txn(-536870912, lat, c, s, ir);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      theta_in = 32'sd100;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cos_out !== c || sin_out !== s) bad++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad !== 0 || lat !== NI) begin
      n_bad++;
      $display("FAIL backpressure_hold: got %0d unstable cycles lat=%0d want 0 %0d", bad, lat, NI);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01 || cos_out !== c || sin_out !== s) begin
      n_bad++;
      $display("FAIL backpressure_release: got valid/ready=%b cos=%0d want 01 %0d", {out_valid, in_ready}, cos_out, c);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL backpressure_no_queue: got busy/valid=%b want 00", {busy, out_valid});
    end
  endtask

  task automatic test_reset_abort();
    int lat, c, s, ir, seen;
    out_ready = 1'b1;
    @(negedge clk);
    theta_in = 842887823;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000 || cos_out !== '0 || sin_out !== '0) begin
      n_bad++;
      $display("FAIL abort_reset_state: got flags=%b cos=%0d sin=%0d want 000 0 0",
               {in_ready, out_valid, busy}, cos_out, sin_out);
    end
    seen = 0;
    repeat (NI + 4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || seen !== 0) begin
      n_bad++;
      $display("FAIL abort_release: got in_ready=%b valid_seen=%0d want 1 0", in_ready, seen);
    end
    do_txn(-536870912, lat, c, s, ir);
    n_cmp++;
    if (c - ref_cos(-536870912) > TOL || ref_cos(-536870912) - c > TOL ||
        s - ref_sin(-536870912) > TOL || ref_sin(-536870912) - s > TOL || lat !== NI) begin
      n_bad++;
      $display("FAIL abort_recover: got cos=%0d sin=%0d lat=%0d want %0d %0d %0d",
               c, s, lat, ref_cos(-536870912), ref_sin(-536870912), NI);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cnt, c1, s1, c2, s2, w;
    out_ready = 1'b1;
    @(negedge clk);
    theta_in = 1686629713;
    in_valid = 1'b1;
    @(negedge clk);
    theta_in = -1686629713;
    cnt = 1;
    c1 = 12345;
    s1 = 12345;
    while (!in_ready && cnt < 200) begin
      if (out_valid) begin
        c1 = cos_out;
        s1 = sin_out;
      end
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== NI + 2) begin
      n_bad++;
      $display("FAIL b2b_interval: got %0d want %0d", cnt, NI + 2);
    end
    n_cmp++;
    if (c1 - ref_cos(1686629713) > TOL || ref_cos(1686629713) - c1 > TOL ||
        s1 - ref_sin(1686629713) > TOL || ref_sin(1686629713) - s1 > TOL) begin
      n_bad++;
      $display("FAIL b2b_first: got cos=%0d sin=%0d want %0d %0d", c1, s1,
               ref_cos(1686629713), ref_sin(1686629713));
    end
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    c2 = cos_out;
    s2 = sin_out;
    n_cmp++;
    if (c2 - ref_cos(-1686629713) > TOL || ref_cos(-1686629713) - c2 > TOL ||
        s2 - ref_sin(-1686629713) > TOL || ref_sin(-1686629713) - s2 > TOL || w !== NI) begin
      n_bad++;
      $display("FAIL b2b_second: got cos=%0d sin=%0d wait=%0d want %0d %0d %0d", c2, s2, w,
               ref_cos(-1686629713), ref_sin(-1686629713), NI);
    end
    @(negedge clk);
  endtask

`ifdef CORDIC_QUADRANT_FOLD_EN
  task automatic test_fold();
    int thetas [2] = '{2040109465, -2040109465};
    int lat, c, s, ir;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      do_txn(thetas[k], lat, c, s, ir);
      n_cmp++;
      if (c - ref_cos(thetas[k]) > TOL || ref_cos(thetas[k]) - c > TOL ||
          s - ref_sin(thetas[k]) > TOL || ref_sin(thetas[k]) - s > TOL) begin
        n_bad++;
        $display("FAIL fold[%0d]: got cos=%0d sin=%0d want %0d %0d", k, c, s,
                 ref_cos(thetas[k]), ref_sin(thetas[k]));
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero();
    test_angles();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
`ifdef CORDIC_QUADRANT_FOLD_EN
    test_fold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
